// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time against an internal word array.
// Latency: access WAIT_CYCLES+1 edges after acceptance, one-cycle resp_valid pulse after that.
// Backpressure: req_ready only in IDLE; no response backpressure, resp_* valid for one cycle.
module data_mem_responder #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_byte,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [3:0]               cnt;
    logic                     lat_write;
    logic                     lat_byte;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [DATA_WIDTH-1:0]    mem [MEM_SIZE];

    logic                     accept;
    logic                     do_access;
    logic                     in_range;
    logic [MEM_AW-1:0]        mem_idx;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic [DATA_WIDTH-1:0]    load_dat;

    // Ready is gated by reset so nothing is taken while reset is asserted.
    assign req_ready  = (state == S_IDLE) && rst;
    assign accept     = req_valid && req_ready;
    assign do_access  = (state == S_WAIT) && (cnt == 4'd0);
    assign in_range   = {1'b0, lat_addr} < MEM_LIMIT;
    assign mem_idx    = lat_addr[MEM_AW-1:0];
    assign rd_word    = mem[mem_idx];
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_RESP);

    always_comb begin
        load_dat = '0;
        if (in_range && !lat_write) begin
            load_dat = lat_byte ? {{(DATA_WIDTH-8){1'b0}}, rd_word[7:0]} : rd_word;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                resp_rdata <= load_dat;
                resp_err   <= !in_range;
            end else if (state == S_RESP) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_byte  <= req_byte;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Array is not reset; a reset forces IDLE, so a pending store never lands.
    always_ff @(posedge clk) begin
        if (do_access && lat_write && in_range) begin
            if (lat_byte) begin
                mem[mem_idx][7:0] <= lat_wdata[7:0];
            end else begin
                mem[mem_idx] <= lat_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 has WAIT_CYCLES=2/MEM_SIZE=128, instance 1 WAIT_CYCLES=0.
// Expected responses are queued at acceptance and checked when resp_valid appears.
module tb_data_mem_responder;

    typedef struct {
        logic [19:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  rv, rw, rb, rdy, resp_v, err, busy_s;
    logic [7:0]  raddr [2];
    logic [19:0] wd [2];
    logic [19:0] rd [2];

    exp_t qa[$];
    exp_t qb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(128), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]), .req_byte(rb[0]),
        .req_addr(raddr[0]), .req_wdata(wd[0]),
        .resp_valid(resp_v[0]), .resp_rdata(rd[0]), .resp_err(err[0]), .busy(busy_s[0])
    );

    data_mem_responder #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(256), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]), .req_byte(rb[1]),
        .req_addr(raddr[1]), .req_wdata(wd[1]),
        .resp_valid(resp_v[1]), .resp_rdata(rd[1]), .resp_err(err[1]), .busy(busy_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input int d, input logic w, input logic b, input logic [7:0] a,
                        input logic [19:0] wdat, input logic [19:0] exp_rd,
                        input logic exp_err, input bit push);
        exp_t e;
        bit   done = 0;
        int   n    = 0;
        rv[d] = 1'b1; rw[d] = w; rb[d] = b; raddr[d] = a; wd[d] = wdat;
        while (!done && n < 50) begin
            if (rdy[d]) begin
                e.rdata = exp_rd;
                e.err   = exp_err;
                e.due   = cyc + wc(d) + 2;
                if (push) begin
                    if (d == 0) qa.push_back(e);
                    else        qb.push_back(e);
                end
                @(posedge clk);
                @(negedge clk);
                done = 1;
            end else begin
                chk($sformatf("busy_while_not_ready%0d", d), {31'd0, busy_s[d]}, 32'd1);
                @(negedge clk);
                n++;
            end
        end
        rv[d] = 1'b0;
        chk($sformatf("accepted%0d", d), {31'd0, done}, 32'd1);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (((d == 0) ? qa.size() : qb.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d", d), (d == 0) ? qa.size() : qb.size(), 32'd0);
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (resp_v[d]) begin
            chk($sformatf("resp_expected%0d", d), {31'd0, ((d == 0) ? qa.size() : qb.size()) != 0}, 32'd1);
            if (((d == 0) ? qa.size() : qb.size()) != 0) begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("rdata%0d", d), {12'd0, rd[d]}, {12'd0, e.rdata});
                chk($sformatf("err%0d", d), {31'd0, err[d]}, {31'd0, e.err});
                chk($sformatf("latency%0d", d), cyc, e.due);
            end
        end else begin
            chk($sformatf("idle_outputs%0d", d), {11'd0, err[d], rd[d]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rv = '0; rw = '0; rb = '0;
        for (int i = 0; i < 2; i++) begin
            raddr[i] = '0;
            wd[i]    = '0;
        end

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i), {31'd0, rdy[i]}, 32'd0);
            chk($sformatf("rst_busy%0d", i), {31'd0, busy_s[i]}, 32'd0);
            chk($sformatf("rst_valid%0d", i), {31'd0, resp_v[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release0", {31'd0, rdy[0]}, 32'd1);
        chk("ready_after_release1", {31'd0, rdy[1]}, 32'd1);

        // Word store then load
        send(0, 1'b1, 1'b0, 8'h10, 20'hABCDE, 20'h00000, 1'b0, 1);
        drain(0);
        send(0, 1'b0, 1'b0, 8'h10, 20'h00000, 20'hABCDE, 1'b0, 1);
        drain(0);

        // Byte store preserves upper bits; byte load zero-extends
        send(0, 1'b1, 1'b0, 8'h20, 20'h12345, 20'h00000, 1'b0, 1);
        drain(0);
        send(0, 1'b1, 1'b1, 8'h20, 20'hFF0A5, 20'h00000, 1'b0, 1);
        drain(0);
        send(0, 1'b0, 1'b0, 8'h20, 20'h00000, 20'h123A5, 1'b0, 1);
        drain(0);
        send(0, 1'b0, 1'b1, 8'h20, 20'h00000, 20'h000A5, 1'b0, 1);
        drain(0);

        // Out of range: 0x90 aliases 0x10 in the low bits, which must stay intact
        send(0, 1'b1, 1'b0, 8'h90, 20'h77777, 20'h00000, 1'b1, 1);
        drain(0);
        send(0, 1'b0, 1'b0, 8'h90, 20'h00000, 20'h00000, 1'b1, 1);
        drain(0);
        send(0, 1'b0, 1'b0, 8'h10, 20'h00000, 20'hABCDE, 1'b0, 1);
        drain(0);

        // Second request held while busy; accepted only once back in IDLE
        send(0, 1'b0, 1'b0, 8'h20, 20'h00000, 20'h123A5, 1'b0, 1);
        send(0, 1'b1, 1'b0, 8'h30, 20'h3C3C3, 20'h00000, 1'b0, 1);
        drain(0);
        send(0, 1'b0, 1'b0, 8'h30, 20'h00000, 20'h3C3C3, 1'b0, 1);
        drain(0);

        // Reset during WAIT drops the pending store
        send(0, 1'b1, 1'b0, 8'h40, 20'h11111, 20'h00000, 1'b0, 1);
        drain(0);
        send(0, 1'b1, 1'b0, 8'h40, 20'h55555, 20'h00000, 1'b0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_s[0]}, 32'd0);
        chk("midrst_ready", {31'd0, rdy[0]}, 32'd0);
        chk("midrst_outputs", {11'd0, err[0], rd[0]}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(0, 1'b0, 1'b0, 8'h40, 20'h00000, 20'h11111, 1'b0, 1);
        drain(0);

        // Zero wait cycles: back-to-back loads presented as soon as ready
        send(1, 1'b1, 1'b0, 8'h05, 20'h0F0F0, 20'h00000, 1'b0, 1);
        drain(1);
        send(1, 1'b1, 1'b0, 8'h06, 20'h24680, 20'h00000, 1'b0, 1);
        drain(1);
        send(1, 1'b0, 1'b0, 8'h05, 20'h00000, 20'h0F0F0, 1'b0, 1);
        send(1, 1'b0, 1'b0, 8'h06, 20'h00000, 20'h24680, 1'b0, 1);
        send(1, 1'b0, 1'b1, 8'h06, 20'h00000, 20'h00080, 1'b0, 1);
        drain(1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
